// File: rtl/param_datapath_pkg.sv
// Shared opcode/shift encodings and sequencer state type for param_datapath.
package param_datapath_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_MVN = 3'b011;
  localparam logic [2:0] OP_MOV = 3'b100;
  localparam logic [2:0] OP_CMP = 3'b101;
  localparam logic [2:0] OP_ORR = 3'b110;
  localparam logic [2:0] OP_EOR = 3'b111;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL1 = 2'b01;
  localparam logic [1:0] SH_LSR1 = 2'b10;
  localparam logic [1:0] SH_ASR1 = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_A,
    ST_LOAD_B,
    ST_EXEC,
    ST_WB
  } state_t;

endpackage

// File: rtl/param_datapath_if.sv
// Decoder/memory-side bus of param_datapath: op request, immediate write, result and debug read.
interface param_datapath_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 3
);
  logic             start;
  logic [2:0]       opcode;
  logic [1:0]       shift;
  logic [AW-1:0]    rd;
  logic [AW-1:0]    rn;
  logic [AW-1:0]    rm;
  logic             imm_we;
  logic [AW-1:0]    imm_addr;
  logic [WIDTH-1:0] datapath_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] datapath_out;
  logic [2:0]       status;
  logic [AW-1:0]    dbg_addr;
  logic [WIDTH-1:0] dbg_data;

  modport master (
    output start, opcode, shift, rd, rn, rm, imm_we, imm_addr, datapath_in, dbg_addr,
    input  busy, done, datapath_out, status, dbg_data
  );

  modport slave (
    input  start, opcode, shift, rd, rn, rm, imm_we, imm_addr, datapath_in, dbg_addr,
    output busy, done, datapath_out, status, dbg_data
  );
endinterface

// File: rtl/param_regfile.sv
// NREGS x WIDTH register file: one synchronous write port, operand and debug combinational reads.
module param_regfile #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);
  logic [WIDTH-1:0] regs [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '{default: '0};
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata    = regs[raddr];
  assign dbg_data = regs[dbg_addr];
endmodule

// File: rtl/param_datapath.sv
// Parametrised CPU datapath with built-in read-A/read-B/execute/write-back sequencer.
// Define STATUS_NV_EN to compute the N and V status flags; otherwise only Z is produced.
module param_datapath
  import param_datapath_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREGS = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  param_datapath_if.slave bus
);
  localparam int AW = $clog2(NREGS);

  state_t           state, state_nxt;
  logic [2:0]       op_q;
  logic [1:0]       sh_q;
  logic [AW-1:0]    rd_q, rn_q, rm_q;
  logic [WIDTH-1:0] a_q, b_q, c_q;
  logic [2:0]       status_q, status_nxt;

  logic             rf_we;
  logic [AW-1:0]    rf_waddr, op_raddr;
  logic [WIDTH-1:0] rf_wdata, op_rdata;
  logic [WIDTH-1:0] b_sh, alu_y, sum, diff;

  param_regfile #(.WIDTH(WIDTH), .NREGS(NREGS), .AW(AW)) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (rf_we),
    .waddr    (rf_waddr),
    .wdata    (rf_wdata),
    .raddr    (op_raddr),
    .rdata    (op_rdata),
    .dbg_addr (bus.dbg_addr),
    .dbg_data (bus.dbg_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Write port is shared: immediates only in IDLE, results only in WB.
  always_comb begin
    state_nxt = state;
    rf_we     = 1'b0;
    rf_waddr  = bus.imm_addr;
    rf_wdata  = bus.datapath_in;
    op_raddr  = (state == ST_LOAD_B) ? rm_q : rn_q;
    case (state)
      ST_IDLE: begin
        rf_we = bus.imm_we;
        if (bus.start) state_nxt = ST_LOAD_A;
      end
      ST_LOAD_A: state_nxt = ST_LOAD_B;
      ST_LOAD_B: state_nxt = ST_EXEC;
      ST_EXEC:   state_nxt = ST_WB;
      ST_WB: begin
        rf_we     = (op_q != OP_CMP);
        rf_waddr  = rd_q;
        rf_wdata  = c_q;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    case (sh_q)
      SH_LSL1: b_sh = {b_q[WIDTH-2:0], 1'b0};
      SH_LSR1: b_sh = {1'b0, b_q[WIDTH-1:1]};
      SH_ASR1: b_sh = {b_q[WIDTH-1], b_q[WIDTH-1:1]};
      default: b_sh = b_q;
    endcase
  end

  assign sum  = a_q + b_sh;
  assign diff = a_q - b_sh;

  always_comb begin
    case (op_q)
      OP_ADD:         alu_y = sum;
      OP_SUB, OP_CMP: alu_y = diff;
      OP_AND:         alu_y = a_q & b_sh;
      OP_MVN:         alu_y = ~b_sh;
      OP_MOV:         alu_y = b_sh;
      OP_ORR:         alu_y = a_q | b_sh;
      default:        alu_y = a_q ^ b_sh;
    endcase
  end

`ifdef STATUS_NV_EN
  logic alu_v;
  always_comb begin
    case (op_q)
      OP_ADD:         alu_v = (a_q[WIDTH-1] == b_sh[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      OP_SUB, OP_CMP: alu_v = (a_q[WIDTH-1] != b_sh[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
      default:        alu_v = 1'b0;
    endcase
    status_nxt = {alu_v, alu_y[WIDTH-1], (alu_y == '0)};
  end
`else
  assign status_nxt = {2'b00, (alu_y == '0)};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      sh_q     <= '0;
      rd_q     <= '0;
      rn_q     <= '0;
      rm_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      status_q <= '0;
    end else begin
      case (state)
        ST_IDLE: if (bus.start) begin
          op_q <= bus.opcode;
          sh_q <= bus.shift;
          rd_q <= bus.rd;
          rn_q <= bus.rn;
          rm_q <= bus.rm;
        end
        ST_LOAD_A: a_q <= op_rdata;
        ST_LOAD_B: b_q <= op_rdata;
        ST_EXEC: begin
          c_q      <= alu_y;
          status_q <= status_nxt;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy         = (state != ST_IDLE);
  assign bus.done         = (state == ST_WB);
  assign bus.datapath_out = c_q;
  assign bus.status       = status_q;
endmodule

// File: tb/tb_param_datapath.sv
// Self-checking bench for param_datapath (WIDTH=16, NREGS=8): directed cases plus random ops vs a arithmetic model.
module tb_param_datapath;
  import param_datapath_pkg::*;

  localparam int W = 16;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  param_datapath_if #(.WIDTH(W), .AW(3)) bus ();
  param_datapath #(.WIDTH(W), .NREGS(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int errors = 0;
  int checks = 0;
  int unsigned mreg [N];
  int unsigned mc, mstat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned shf(input int unsigned b, input int unsigned sh);
    case (sh)
      0:       return b;
      1:       return (b * 2) % 65536;
      2:       return b / 2;
      default: return b / 2 + ((b >= 32768) ? 32768 : 0);
    endcase
  endfunction

  function automatic longint sgn(input int unsigned x);
    return (x >= 32768) ? longint'(x) - 65536 : longint'(x);
  endfunction

  task automatic model_op(input int unsigned op, sh, rd, rn, rm);
    int unsigned a = mreg[rn];
    int unsigned b = shf(mreg[rm], sh);
    int unsigned y;
    longint s;
    bit v = 0;
    case (op)
      0: begin y = (a + b) % 65536; s = sgn(a) + sgn(b); v = (s > 32767) || (s < -32768); end
      1, 5: begin y = (a + 65536 - b) % 65536; s = sgn(a) - sgn(b); v = (s > 32767) || (s < -32768); end
      2: y = a & b;
      3: y = (~b) & 32'hFFFF;
      4: y = b;
      6: y = a | b;
      default: y = a ^ b;
    endcase
`ifdef STATUS_NV_EN
    mstat = (v ? 4 : 0) + ((y >= 32768) ? 2 : 0) + ((y == 0) ? 1 : 0);
`else
    mstat = (y == 0) ? 1 : 0;
`endif
    mc = y;
    if (op != 5) mreg[rd] = y;
  endtask

  task automatic imm(input int unsigned a, input int unsigned d);
    @(negedge clk);
    bus.imm_we = 1'b1;
    bus.imm_addr = a[2:0];
    bus.datapath_in = d[15:0];
    @(posedge clk);
    #1 bus.imm_we = 1'b0;
    mreg[a] = d & 32'hFFFF;
  endtask

  task automatic rd_chk(input string tag, input int unsigned a, input int unsigned exp);
    bus.dbg_addr = a[2:0];
    #1 check(tag, bus.dbg_data, exp);
  endtask

  // Optional same-edge immediate write; optional start/imm_we noise held while busy.
  task automatic do_op(input int unsigned op, sh, rd, rn, rm,
                       input bit with_imm = 0, input int unsigned ia = 0, input int unsigned id = 0,
                       input bit noise = 0);
    int n = 0;
    int unsigned na = (rd + 1) % N;
    @(negedge clk);
    bus.start = 1'b1;
    bus.opcode = op[2:0];
    bus.shift = sh[1:0];
    bus.rd = rd[2:0];
    bus.rn = rn[2:0];
    bus.rm = rm[2:0];
    bus.dbg_addr = rd[2:0];
    if (with_imm) begin
      bus.imm_we = 1'b1;
      bus.imm_addr = ia[2:0];
      bus.datapath_in = id[15:0];
      mreg[ia] = id & 32'hFFFF;
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.imm_we = 1'b0;
    if (noise) begin
      bus.start = 1'b1;
      bus.opcode = 3'd7;
      bus.rd = na[2:0];
      bus.imm_we = 1'b1;
      bus.imm_addr = na[2:0];
      bus.datapath_in = 16'hBEEF;
    end
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < 8);
    check("done_latency", n, 4);
    check("busy_at_done", bus.busy, 1);
    bus.start = 1'b0;
    bus.imm_we = 1'b0;
    model_op(op, sh, rd, rn, rm);
    @(posedge clk);
    #1;
    check("busy_after", bus.busy, 0);
    check("done_after", bus.done, 0);
    check("datapath_out", bus.datapath_out, mc);
    check("status", bus.status, mstat);
    check("reg_rd", bus.dbg_data, mreg[rd]);
    if (noise) begin
      rd_chk("noise_reg", na, mreg[na]);
      @(negedge clk);
      check("noise_idle1", bus.busy, 0);
      @(negedge clk);
      check("noise_idle2", bus.busy, 0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.opcode = '0;
    bus.shift = '0;
    bus.rd = '0;
    bus.rn = '0;
    bus.rm = '0;
    bus.imm_we = 1'b0;
    bus.imm_addr = '0;
    bus.datapath_in = '0;
    bus.dbg_addr = '0;
    for (int i = 0; i < N; i++) mreg[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_out", bus.datapath_out, 0);
    check("rst_status", bus.status, 0);
    for (int i = 0; i < N; i++) rd_chk("rst_reg", i, 0);
    @(negedge clk);
    rst_n = 1'b1;

    imm(0, 7); imm(1, 2);
    do_op(0, 1, 2, 1, 0);
    rd_chk("t1_r2", 2, 16);
    check("t1_z", bus.status[0], 0);

    imm(0, 13); imm(1, 7);
    do_op(1, 2, 2, 0, 1);
    rd_chk("t2_r2", 2, 10);
    check("t2_status", bus.status, 0);

    imm(3, 5); imm(4, 5); imm(7, 32'h1234);
    do_op(5, 0, 7, 3, 4);
    check("t3_z", bus.status[0], 1);
    rd_chk("t3_r7", 7, 32'h1234);

    imm(0, 32'h7FFF); imm(1, 1);
    do_op(0, 0, 6, 0, 1);
    rd_chk("t4_r6", 6, 32'h8000);
`ifdef STATUS_NV_EN
    check("t4_status", bus.status, 3'b110);
`else
    check("t4_status", bus.status, 3'b000);
`endif

    imm(5, 32'h8000);
    do_op(3, 3, 7, 0, 5);
    rd_chk("t5_r7", 7, 32'h3FFF);
    check("t5_n", bus.status[1], 0);
    check("t5_z", bus.status[0], 0);

    do_op(0, 0, 3, 0, 1, 0, 0, 0, 1);
    do_op(0, 0, 2, 4, 4, 1, 4, 100);
    rd_chk("same_edge_r2", 2, 200);
    do_op(0, 0, 1, 1, 1);

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(1, 0) == 1) imm($urandom_range(N - 1, 0), $urandom_range(65535, 0));
      do_op($urandom_range(7, 0), $urandom_range(3, 0), $urandom_range(N - 1, 0),
            $urandom_range(N - 1, 0), $urandom_range(N - 1, 0),
            bit'($urandom_range(3, 0) == 0), $urandom_range(N - 1, 0), $urandom_range(65535, 0),
            bit'($urandom_range(4, 0) == 0));
    end

    imm(0, 32'h00F0); imm(1, 32'h000F);
    @(negedge clk);
    bus.start = 1'b1; bus.opcode = 3'd0; bus.shift = 2'd0;
    bus.rd = 3'd2; bus.rn = 3'd0; bus.rm = 3'd1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("exec_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    @(posedge clk);
    #1;
    check("abort_done_e3", bus.done, 0);
    check("abort_out", bus.datapath_out, 0);
    check("abort_status", bus.status, 0);
    for (int i = 0; i < N; i++) rd_chk("abort_reg", i, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_abort_busy", bus.busy, 0);
    check("post_abort_done", bus.done, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
